// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational arithmetic ALU between NUM_REQ requesters.
// Each operation walks IDLE -> ISSUE -> RESPOND, with the result latched for the response handshake.
module alu_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned XLEN    = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*XLEN-1:0] req_lhs,
   input  logic [NUM_REQ*XLEN-1:0] req_rhs,
   input  logic [NUM_REQ*3-1:0]    req_operation,
   input  logic [NUM_REQ*7-1:0]    req_metadata,
   output logic [NUM_REQ-1:0]      rsp_valid,
   input  logic [NUM_REQ-1:0]      rsp_ready,
   output logic [XLEN-1:0]         rsp_result,
   output logic                    rsp_illegal,
   output logic [XLEN-1:0]         alu_lhs,
   output logic                    alu_lhs_valid,
   output logic [XLEN-1:0]         alu_rhs,
   output logic                    alu_rhs_valid,
   output logic [2:0]              alu_operation,
   output logic                    alu_operation_valid,
   output logic [6:0]              alu_metadata,
   output logic                    alu_metadata_valid,
   input  logic [XLEN-1:0]         alu_result,
   input  logic                    alu_arithmetic_code_legal,
   input  logic                    alu_result_valid,
   output logic [15:0]             completed_count
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RESPOND = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  grant;
   logic [IDX_W-1:0]  sel_idx;
   logic              sel_found;
   logic              accept;
   logic              rsp_done;
   logic              alu_drive;

   logic [XLEN-1:0]   lhs_arr  [NUM_REQ];
   logic [XLEN-1:0]   rhs_arr  [NUM_REQ];
   logic [2:0]        op_arr   [NUM_REQ];
   logic [6:0]        meta_arr [NUM_REQ];

   // Unpack the per-requester slices for indexed selection.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
      assign lhs_arr[g]  = req_lhs[g*XLEN +: XLEN];
      assign rhs_arr[g]  = req_rhs[g*XLEN +: XLEN];
      assign op_arr[g]   = req_operation[g*3 +: 3];
      assign meta_arr[g] = req_metadata[g*7 +: 7];
   end

   // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid index overall.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         if (req_valid[i] && (IDX_W'(i) >= rr_ptr)) begin
            sel_idx = IDX_W'(i);
         end
      end
   end

   assign accept   = (state == IDLE) && sel_found;
   assign rsp_done = (state == RESPOND) && rsp_ready[grant];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ISSUE;
         ISSUE:   state_nxt = RESPOND;
         RESPOND: if (rsp_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake strobes; req_ready is gated by rst so it drops during reset as well.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      alu_drive = 1'b0;
      case (state)
         IDLE:    if (sel_found && !rst) req_ready[sel_idx] = 1'b1;
         ISSUE:   alu_drive = 1'b1;
         RESPOND: rsp_valid[grant] = 1'b1;
         default: ;
      endcase
   end

   assign alu_lhs_valid       = alu_drive;
   assign alu_rhs_valid       = alu_drive;
   assign alu_operation_valid = alu_drive;
   assign alu_metadata_valid  = alu_drive;

   // Operand capture, result capture and round-robin / completion bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_lhs         <= '0;
         alu_rhs         <= '0;
         alu_operation   <= '0;
         alu_metadata    <= '0;
         grant           <= '0;
         rr_ptr          <= '0;
         rsp_result      <= '0;
         rsp_illegal     <= 1'b0;
         completed_count <= '0;
      end else begin
         if (accept) begin
            alu_lhs       <= lhs_arr[sel_idx];
            alu_rhs       <= rhs_arr[sel_idx];
            alu_operation <= op_arr[sel_idx];
            alu_metadata  <= meta_arr[sel_idx];
            grant         <= sel_idx;
         end
         if (state == ISSUE) begin
            if (alu_arithmetic_code_legal && alu_result_valid) begin
               rsp_result  <= alu_result;
               rsp_illegal <= 1'b0;
            end else begin
               rsp_result  <= '0;
               rsp_illegal <= 1'b1;
            end
         end
         if (rsp_done) begin
            rr_ptr          <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
            completed_count <= completed_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational `arithmetic` ALU between NUM_REQ requesters, e.g. the integer execute path and the address/branch helper.
- Each requester issues an operation with lhs, rhs, funct3 and funct7 over a valid/ready handshake.
- The arbiter grants one requester round-robin, drives the ALU for one cycle and latches the result and legality.
- It returns the response to the granted requester over a second valid/ready handshake.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- XLEN, 32, operand and result width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accept (one-hot or zero).
- req_lhs  in  NUM_REQ*XLEN  packed lhs operands; slice i belongs to requester i.
- req_rhs  in  NUM_REQ*XLEN  packed rhs operands.
- req_operation  in  NUM_REQ*3  packed funct3 codes.
- req_metadata  in  NUM_REQ*7  packed funct7 codes.
- rsp_valid  out  NUM_REQ  per-requester response valid (one-hot or zero).
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_result  out  XLEN  latched ALU result; forced to 0 when illegal.
- rsp_illegal  out  1  latched "arithmetic code illegal" flag.
- alu_lhs  out  XLEN  drives ALU lhs.
- alu_lhs_valid  out  1  drives ALU lhs_valid.
- alu_rhs  out  XLEN  drives ALU rhs.
- alu_rhs_valid  out  1  drives ALU rhs_valid.
- alu_operation  out  3  drives ALU operation [14:12].
- alu_operation_valid  out  1  drives ALU operation_valid.
- alu_metadata  out  7  drives ALU metadata [31:25].
- alu_metadata_valid  out  1  drives ALU metadata_valid.
- alu_result  in  XLEN  ALU result.
- alu_arithmetic_code_legal  in  1  ALU legality.
- alu_result_valid  in  1  ALU result valid.
- completed_count  out  16  number of responses accepted; wraps at 0xFFFF -> 0.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0, grant=0.
  - Operand, result and illegal registers cleared; completed_count=0.
  - All req_ready, rsp_valid and alu_*_valid are 0; all alu data outputs are 0.
  - Reset mid-transaction drops the in-flight operation silently; no response is ever produced for it.
- State machine IDLE -> ISSUE -> RESPOND -> IDLE.
- IDLE:
  - Combinationally select the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Assert req_ready[i] for that i only, and only in IDLE.
  - On the clock edge with req_valid[i] & req_ready[i]: latch slice i operands and codes, set grant=i, go to ISSUE.
  - No request valid: stay in IDLE; all outputs idle.
- ISSUE (exactly one cycle):
  - Drive alu_* data from the latched registers; all four alu_*_valid=1.
  - At the edge, capture the ALU outputs:
    - Legal and result_valid: rsp_result=alu_result, rsp_illegal=0.
    - Otherwise: rsp_result=0, rsp_illegal=1.
  - Go to RESPOND.
- RESPOND:
  - rsp_valid[grant]=1, all other rsp_valid bits 0.
  - rsp_result and rsp_illegal stay stable until the handshake completes.
  - On rsp_ready[grant]=1 at the edge: go to IDLE, rr_ptr=(grant+1) mod NUM_REQ, completed_count+=1.
  - rsp_ready of non-granted requesters is ignored.
- Latency and throughput:
  - Request accepted at edge N; rsp_valid high in the cycle after edge N+1.
  - Best case 3 cycles per operation (one op per 3 cycles).
- Fairness: a continuously requesting port waits at most NUM_REQ-1 operations.
- Simultaneous events:
  - New req_valid during ISSUE/RESPOND is not accepted (req_ready=0); the requester must hold valid and operands stable.
  - Requests from all ports in IDLE: only the round-robin winner is readied.
- ALU outputs outside ISSUE: all alu_*_valid=0 in IDLE/RESPOND; data outputs hold the last latched values.

Test Plan:
- Reset: rst=1 asynchronously mid-cycle -> all req_ready/rsp_valid/alu_*_valid 0 and completed_count=0 immediately; after release, the arbiter is IDLE and accepts a new request.
- Single add: req0 lhs=0x0000_0001, rhs=0x0000_FFFF, op=0, meta=0x00, rsp_ready held 1 -> req_ready[0] pulses one cycle, alu valids high exactly one cycle, rsp_valid[0]=1 with rsp_result=0x0001_0000, rsp_illegal=0, completed_count=1.
- Illegal code: req1 op=0, meta=0x01 -> rsp_valid[1]=1, rsp_illegal=1, rsp_result=0.
- Round-robin: both requesters valid continuously; req0 SUB 0-1, req1 SRA 0xA863_201F>>4 -> grant order 0,1,0,1; results 0xFFFF_FFFF and 0xFA86_3201; rr_ptr alternates.
- Backpressure: rsp_ready[0]=0 for 5 cycles after rsp_valid[0] -> rsp_valid and result stable; req1 valid meanwhile sees req_ready[1]=0; on rsp_ready[0]=1, req1 is granted next.
- Reset mid-RESPOND: rst asserted while rsp_valid[0]=1 -> rsp_valid drops at once, completed_count=0, no response delivered after release.
